// File: rtl/mon_axi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mon_axi_master
// Purpose  : Bridges the UART monitor data-RAM request port onto a 128-bit
//            AXI4-Lite-style master. Writes are buffered in a small FIFO and
//            one AXI transaction runs at a time; reads wait behind writes.
// Options  : MON_AXI_TIMEOUT_EN - response timeout with DRAIN recovery state
// Revision : 1.0 - initial release
// ============================================================================
module mon_axi_master #(
   parameter int unsigned WQ_DEPTH = 4,
   parameter int unsigned TIMEOUT  = 1024
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [31:0]    d_ram_wadr,
   input  logic [127:0]   d_ram_wdata,
   input  logic [15:0]    d_ram_mask,
   input  logic           d_ram_wen,
   input  logic [31:0]    d_ram_radr,
   input  logic           dread_start,
   output logic [127:0]   d_ram_rdata,
   output logic           read_valid,
   output logic           wq_full,
   output logic           axi_err,
   output logic [31:0]    awaddr,
   output logic           awvalid,
   input  logic           awready,
   output logic [127:0]   wdata,
   output logic [15:0]    wstrb,
   output logic           wvalid,
   input  logic           wready,
   input  logic [1:0]     bresp,
   input  logic           bvalid,
   output logic           bready,
   output logic [31:0]    araddr,
   output logic           arvalid,
   input  logic           arready,
   input  logic [127:0]   rdata,
   input  logic [1:0]     rresp,
   input  logic           rvalid,
   output logic           rready
);
   localparam int unsigned    c_PW   = $clog2(WQ_DEPTH);
   localparam int unsigned    c_CW   = $clog2(WQ_DEPTH + 1);
   localparam logic [c_CW-1:0] c_FULL = c_CW'(WQ_DEPTH);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WADDR = 3'd1,
      WRESP = 3'd2,
      RADDR = 3'd3,
      RDATA = 3'd4
`ifdef MON_AXI_TIMEOUT_EN
      , DRAIN = 3'd5
`endif
   } state_t;

   state_t          state_q, state_d;
   logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic            arvalid_q, arvalid_d, rready_q, rready_d;
   logic [31:0]     awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [127:0]    wdata_q, wdata_d, rdata_q, rdata_d;
   logic [15:0]     wstrb_q, wstrb_d;
   logic            read_valid_q, read_valid_d;

   // write queue storage and bookkeeping; only the line address is kept
   logic [27:0]     wq_adr_q  [WQ_DEPTH];
   logic [127:0]    wq_data_q [WQ_DEPTH];
   logic [15:0]     wq_mask_q [WQ_DEPTH];
   logic [c_PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [c_CW-1:0] count_q;
   logic            pend_q, err_q;
   logic [27:0]     radr_q;

   logic            w_push, w_pop, w_rd_done, w_set_err;
   logic            w_unused_addr_lsb;

`ifdef MON_AXI_TIMEOUT_EN
   localparam int unsigned     c_TW   = $clog2(TIMEOUT + 1);
   localparam logic [c_TW-1:0] c_TLIM = c_TW'(TIMEOUT - 1);
   logic [c_TW-1:0] tmo_q, tmo_d;
`else
   localparam int unsigned c_unused_timeout = TIMEOUT;
`endif

   // low address bits are dropped by line alignment
   assign w_unused_addr_lsb = ^{d_ram_wadr[3:0], d_ram_radr[3:0]};
   assign w_push  = d_ram_wen && (count_q != c_FULL);
   assign wq_full = (count_q == c_FULL);

   // next-state and AXI channel control for the single outstanding transaction
   always_comb begin
      state_d      = state_q;
      awvalid_d    = awvalid_q;
      wvalid_d     = wvalid_q;
      bready_d     = bready_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      awaddr_d     = awaddr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      araddr_d     = araddr_q;
      rdata_d      = rdata_q;
      read_valid_d = 1'b0;
      w_pop        = 1'b0;
      w_rd_done    = 1'b0;
      w_set_err    = 1'b0;
`ifdef MON_AXI_TIMEOUT_EN
      tmo_d        = '0;
`endif
      unique case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               state_d   = WADDR;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               awaddr_d  = {wq_adr_q[rd_ptr_q], 4'h0};
               wdata_d   = wq_data_q[rd_ptr_q];
               wstrb_d   = wq_mask_q[rd_ptr_q];
            end else if (pend_q) begin
               state_d   = RADDR;
               arvalid_d = 1'b1;
               araddr_d  = {radr_q, 4'h0};
            end
         end
         WADDR: begin
            // AW and W complete independently, in either order
            awvalid_d = awvalid_q && !awready;
            wvalid_d  = wvalid_q && !wready;
            if (!awvalid_d && !wvalid_d) begin
               state_d  = WRESP;
               bready_d = 1'b1;
            end
         end
         WRESP: begin
            if (bvalid) begin
               w_pop     = 1'b1;
               w_set_err = (bresp != 2'b00);
               bready_d  = 1'b0;
               state_d   = IDLE;
`ifdef MON_AXI_TIMEOUT_EN
            end else if (tmo_q == c_TLIM) begin
               w_pop     = 1'b1;
               w_set_err = 1'b1;
               state_d   = DRAIN;
            end else begin
               tmo_d     = tmo_q + 1'b1;
`endif
            end
         end
         RADDR: begin
            if (arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RDATA;
            end
         end
         RDATA: begin
            if (rvalid) begin
               rdata_d      = rdata;
               read_valid_d = 1'b1;
               w_rd_done    = 1'b1;
               w_set_err    = (rresp != 2'b00);
               rready_d     = 1'b0;
               state_d      = IDLE;
`ifdef MON_AXI_TIMEOUT_EN
            end else if (tmo_q == c_TLIM) begin
               rdata_d      = '0;
               read_valid_d = 1'b1;
               w_rd_done    = 1'b1;
               w_set_err    = 1'b1;
               state_d      = DRAIN;
            end else begin
               tmo_d        = tmo_q + 1'b1;
`endif
            end
         end
`ifdef MON_AXI_TIMEOUT_EN
         DRAIN: begin
            // keep ready high so the late response is absorbed
            if ((bready_q && bvalid) || (rready_q && rvalid)) begin
               bready_d = 1'b0;
               rready_d = 1'b0;
               state_d  = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // FSM and AXI output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         awaddr_q     <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         araddr_q     <= '0;
         rdata_q      <= '0;
         read_valid_q <= 1'b0;
`ifdef MON_AXI_TIMEOUT_EN
         tmo_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         bready_q     <= bready_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         awaddr_q     <= awaddr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         araddr_q     <= araddr_d;
         rdata_q      <= rdata_d;
         read_valid_q <= read_valid_d;
`ifdef MON_AXI_TIMEOUT_EN
         tmo_q        <= tmo_d;
`endif
      end
   end

   // queue payload storage; contents are don't-care while the entry is free
   always_ff @(posedge clk) begin
      if (w_push) begin
         wq_adr_q[wr_ptr_q]  <= d_ram_wadr[31:4];
         wq_data_q[wr_ptr_q] <= d_ram_wdata;
         wq_mask_q[wr_ptr_q] <= d_ram_mask;
      end
   end

   // queue pointers, pending read request and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         pend_q   <= 1'b0;
         radr_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (w_push && !w_pop)      count_q <= count_q + 1'b1;
         else if (!w_push && w_pop) count_q <= count_q - 1'b1;
         if (w_rd_done) begin
            pend_q <= 1'b0;
         end else if (dread_start && !pend_q) begin
            pend_q <= 1'b1;
            radr_q <= d_ram_radr[31:4];
         end
         if ((d_ram_wen && wq_full) || (dread_start && pend_q) || w_set_err)
            err_q <= 1'b1;
      end
   end

   assign awvalid     = awvalid_q;
   assign wvalid      = wvalid_q;
   assign bready      = bready_q;
   assign arvalid     = arvalid_q;
   assign rready      = rready_q;
   assign awaddr      = awaddr_q;
   assign wdata       = wdata_q;
   assign wstrb       = wstrb_q;
   assign araddr      = araddr_q;
   assign d_ram_rdata = rdata_q;
   assign read_valid  = read_valid_q;
   assign axi_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mon_axi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mon_axi_master
// Purpose  : Scoreboard bench for mon_axi_master with a simple AXI slave model
// Revision : 1.0 - initial release
// ============================================================================
module tb_mon_axi_master;
   localparam int unsigned WQ_DEPTH = 4;
   localparam int unsigned TIMEOUT  = 16;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [31:0] d_ram_wadr = '0, d_ram_radr = '0;
   logic [127:0] d_ram_wdata = '0;
   logic [15:0] d_ram_mask = '0;
   logic d_ram_wen = 1'b0, dread_start = 1'b0;
   logic [127:0] d_ram_rdata, wdata, rdata;
   logic read_valid, wq_full, axi_err;
   logic [31:0] awaddr, araddr;
   logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [15:0] wstrb;
   logic [1:0] bresp, rresp;

   mon_axi_master #(.WQ_DEPTH(WQ_DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .d_ram_wadr(d_ram_wadr), .d_ram_wdata(d_ram_wdata), .d_ram_mask(d_ram_mask),
      .d_ram_wen(d_ram_wen), .d_ram_radr(d_ram_radr), .dread_start(dread_start),
      .d_ram_rdata(d_ram_rdata), .read_valid(read_valid), .wq_full(wq_full), .axi_err(axi_err),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int cyc = 0;
   int b_total = 0, last_b_cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed { logic [127:0] d; logic [15:0] s; } w_t;
   typedef struct { logic [31:0] a; int b; } ar_t;
   typedef struct { logic [127:0] d; int issue; int lat; } rd_t;

   logic [31:0] exp_aw[$];
   w_t          exp_w[$];
   ar_t         exp_ar[$];
   rd_t         exp_rd[$];
   w_t  tw;
   ar_t tar;
   rd_t trd;
   logic prev_rv = 1'b0;

   // slave configuration
   logic [1:0]   cfg_bresp = 2'b00, cfg_rresp = 2'b00;
   logic [127:0] cfg_rdata = '0;
   int           cfg_rdelay = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name, input string what);
      checks++;
      errors++;
      $display("FAIL %s actual=%s required=none", name, what);
   endtask

   // scoreboard monitor: compares every handshake against queued expectations
   always @(negedge clk) begin
      if (rst_n) begin
         if (bvalid && bready) begin
            b_total = b_total + 1;
            last_b_cyc = cyc;
         end
         if (awvalid && awready) begin
            if (exp_aw.size() == 0) flag("aw_extra", "unexpected_aw");
            else check("awaddr", awaddr, exp_aw.pop_front());
         end
         if (wvalid && wready) begin
            if (exp_w.size() == 0) flag("w_extra", "unexpected_w");
            else begin
               tw = exp_w.pop_front();
               check("wdata", wdata, tw.d);
               check("wstrb", wstrb, tw.s);
            end
         end
         if (arvalid && arready) begin
            if (exp_ar.size() == 0) flag("ar_extra", "unexpected_ar");
            else begin
               tar = exp_ar.pop_front();
               check("araddr", araddr, tar.a);
               if (tar.b >= 0) check("ar_after_b", b_total, tar.b);
            end
         end
         if (read_valid) begin
            check("rv_pulse", prev_rv, 1'b0);
            if (exp_rd.size() == 0) flag("rd_extra", "unexpected_read_valid");
            else begin
               trd = exp_rd.pop_front();
               check("rdata", d_ram_rdata, trd.d);
               if (trd.lat >= 0) check("rd_lat", cyc - trd.issue, trd.lat);
            end
         end
      end
      prev_rv = read_valid;
   end

   // AXI slave: B after both AW and W, R after cfg_rdelay cycles
   initial begin : slave
      bit s_aw, s_w, s_b, s_ar, s_r, got_aw, got_w, r_arm;
      int r_wait;
      got_aw = 0; got_w = 0; r_arm = 0; r_wait = 0;
      bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
      forever begin
         @(negedge clk);
         s_aw = awvalid && awready;
         s_w  = wvalid && wready;
         s_b  = bvalid && bready;
         s_ar = arvalid && arready;
         s_r  = rvalid && rready;
         @(posedge clk);
         #2;
         if (!rst_n) begin
            got_aw = 0; got_w = 0; r_arm = 0;
            bvalid = 1'b0; rvalid = 1'b0;
         end else begin
            if (s_b) bvalid = 1'b0;
            if (s_r) rvalid = 1'b0;
            if (s_aw) got_aw = 1;
            if (s_w)  got_w = 1;
            if (got_aw && got_w && !bvalid) begin
               bvalid = 1'b1; bresp = cfg_bresp; got_aw = 0; got_w = 0;
            end
            if (s_ar) begin r_arm = 1; r_wait = cfg_rdelay; end
            if (r_arm && !rvalid) begin
               if (r_wait == 0) begin
                  rvalid = 1'b1; rdata = cfg_rdata; rresp = cfg_rresp; r_arm = 0;
               end else r_wait--;
            end
         end
      end
   end

   task automatic do_write(input logic [31:0] a, input logic [127:0] d, input logic [15:0] m, input bit expect_it);
      if (expect_it) begin
         exp_aw.push_back({a[31:4], 4'h0});
         exp_w.push_back('{d: d, s: m});
      end
      d_ram_wadr = a; d_ram_wdata = d; d_ram_mask = m; d_ram_wen = 1'b1;
      @(posedge clk); #1;
      d_ram_wen = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, input logic [127:0] sd, input logic [127:0] ed,
                          input int lat, input int bexp);
      exp_ar.push_back('{a: {a[31:4], 4'h0}, b: bexp});
      exp_rd.push_back('{d: ed, issue: cyc, lat: lat});
      cfg_rdata = sd;
      d_ram_radr = a; dread_start = 1'b1;
      @(posedge clk); #1;
      dread_start = 1'b0;
   endtask

   task automatic wait_quiet(input string name, input int budget);
      bit done = 0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (exp_aw.size() == 0 && exp_w.size() == 0 && exp_ar.size() == 0 && exp_rd.size() == 0 &&
             !awvalid && !wvalid && !bready && !arvalid && !rready && !bvalid && !rvalid)
            done = 1;
      end
      if (!done) flag(name, "timeout_waiting_idle");
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog actual=hang required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int n;
      bit found;
      awready = 1'b0; wready = 1'b1; arready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      // reset state
      check("rst_awvalid", awvalid, 1'b0);
      check("rst_wvalid", wvalid, 1'b0);
      check("rst_bready", bready, 1'b0);
      check("rst_arvalid", arvalid, 1'b0);
      check("rst_rready", rready, 1'b0);
      check("rst_read_valid", read_valid, 1'b0);
      check("rst_rdata", d_ram_rdata, 128'h0);
      check("rst_wq_full", wq_full, 1'b0);
      check("rst_axi_err", axi_err, 1'b0);
      check("rst_awaddr", awaddr, 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;
      awready = 1'b1;

      // single aligned write, then an empty-queue read
      n = cyc;
      do_write(32'h1000_0014, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'h00F0, 1);
      wait_quiet("t1_write", 50);
      check("wr_lat", last_b_cyc - n, 3);
      check("t1_axi_err", axi_err, 1'b0);
      do_read(32'h0000_1238, 128'h01234567_89ABCDEF_FEDCBA98_76543210,
              128'h01234567_89ABCDEF_FEDCBA98_76543210, 4, -1);
      wait_quiet("t1_read", 50);

      // overflow: 5 pushes with AW stalled
      awready = 1'b0;
      for (int i = 0; i < 5; i++)
         do_write(32'h5000_0004 + 32'(i * 16), {4{32'(i + 1)}}, 16'h000F << i, i < 4);
      @(negedge clk);
      check("t2_wq_full", wq_full, 1'b1);
      check("t2_axi_err", axi_err, 1'b1);
      @(posedge clk); #1 awready = 1'b1;
      wait_quiet("t2_drain", 100);
      check("t2_wq_full_after", wq_full, 1'b0);
      do_reset();
      @(negedge clk);
      check("t2_err_cleared", axi_err, 1'b0);
      @(posedge clk); #1;

      // read ordered behind two writes
      n = b_total;
      do_write(32'h0000_0100, {4{32'hCAFEF00D}}, 16'hFFFF, 1);
      do_write(32'h0000_0200, {4{32'h12345678}}, 16'h0F0F, 1);
      do_read(32'h2000_0008, {16{8'hA5}}, {16{8'hA5}}, -1, n + 2);
      wait_quiet("t3", 100);
      check("t3_axi_err", axi_err, 1'b0);

      // W accepted three cycles ahead of AW
      awready = 1'b0;
      do_write(32'h3000_0024, {4{32'hDEADBEEF}}, 16'hFFFF, 1);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (wvalid && wready) found = 1;
      end
      if (!found) flag("t4_w_hs", "no_w_handshake");
      repeat (3) @(posedge clk);
      #1 awready = 1'b1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (awvalid && awready) found = 1;
      end
      if (!found) flag("t4_aw_hs", "no_aw_handshake");
      @(negedge clk);
      check("t4_bready", bready, 1'b1);
      check("t4_wvalid", wvalid, 1'b0);
      wait_quiet("t4", 50);

      // error response on read is sticky until reset
      cfg_rresp = 2'b10;
      do_read(32'h4000_003C, {4{32'h0BADC0DE}}, {4{32'h0BADC0DE}}, 4, -1);
      wait_quiet("t5_read", 50);
      cfg_rresp = 2'b00;
      check("t5_axi_err", axi_err, 1'b1);
      do_write(32'h4000_0040, {4{32'h55AA55AA}}, 16'hFFFF, 1);
      wait_quiet("t5_write", 50);
      check("t5_axi_err_sticky", axi_err, 1'b1);
      do_reset();
      @(negedge clk);
      check("t5_err_cleared", axi_err, 1'b0);
      @(posedge clk); #1;

`ifdef MON_AXI_TIMEOUT_EN
      // read response withheld past the timeout
      cfg_rdelay = 40;
      do_read(32'h6000_0004, {4{32'h77777777}}, 128'h0, -1, -1);
      wait_quiet("t6_timeout", 200);
      check("t6_axi_err", axi_err, 1'b1);
      cfg_rdelay = 0;
      do_read(32'h6000_0010, {4{32'h13579BDF}}, {4{32'h13579BDF}}, 4, -1);
      wait_quiet("t6_next", 50);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
